// File: rtl/approx_pkg.sv
// Shared definitions for the approximate-adder datapath: FSM encoding, clog2 helper
// and default widths.
package approx_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_APPROX_LSB = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/loa_adder.sv
// Combinational adder: exact a + b by default, lower-part-OR approximate adder when
// APPROX_ADD_EN is defined (APPROX_LSB low bits ORed, carry-in to the upper part from
// the AND of the top approximated bits).
module loa_adder
  import approx_pkg::*;
#(
  parameter int unsigned WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int unsigned APPROX_LSB = DEFAULT_APPROX_LSB
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);

`ifdef APPROX_ADD_EN
  localparam bit APPROX_ON = 1'b1;
`else
  localparam bit APPROX_ON = 1'b0;
`endif

  localparam int unsigned LSB_EFF = !APPROX_ON ? 0 : (APPROX_LSB > WIDTH) ? WIDTH : APPROX_LSB;

  if (LSB_EFF == 0) begin : g_exact
    assign sum = a + b;
  end else if (LSB_EFF == WIDTH) begin : g_all_or
    assign sum = a | b;
  end else begin : g_loa
    localparam int unsigned HI_W = WIDTH - LSB_EFF;
    logic carry;
    assign carry                = a[LSB_EFF-1] & b[LSB_EFF-1];
    assign sum[LSB_EFF-1:0]     = a[LSB_EFF-1:0] | b[LSB_EFF-1:0];
    assign sum[WIDTH-1:LSB_EFF] = a[WIDTH-1:LSB_EFF] + b[WIDTH-1:LSB_EFF] + HI_W'(carry);
  end

endmodule

// File: rtl/fifo_burst_accumulator.sv
// Pops BURST_LEN samples from a registered-output FIFO, sums them through loa_adder
// (approximate when APPROX_ADD_EN is defined) and offers the sum on a valid/ready port.
module fifo_burst_accumulator
  import approx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned ACC_WIDTH  = DATA_WIDTH + clog2(BURST_LEN),
  parameter int unsigned APPROX_LSB = DEFAULT_APPROX_LSB
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic                  fifo_read,
  output logic [ACC_WIDTH-1:0]  sum_out,
  output logic                  sum_valid,
  input  logic                  sum_ready,
  output logic                  busy
);

  localparam int unsigned CNT_W = clog2(BURST_LEN) + 1;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_W-1:0]     issued;
  logic [CNT_W-1:0]     captured;
  logic                 rd_pend;
  logic [ACC_WIDTH-1:0] sample_ext;
  logic [ACC_WIDTH-1:0] add_res;

  assign sample_ext = ACC_WIDTH'(fifo_dout);

  loa_adder #(
    .WIDTH      (ACC_WIDTH),
    .APPROX_LSB (APPROX_LSB)
  ) u_adder (
    .a   (acc),
    .b   (sample_ext),
    .sum (add_res)
  );

  // Combinational so the request drops the moment reset asserts.
  assign fifo_read = (state == ACCUM) && !fifo_empty && (issued < CNT_W'(BURST_LEN));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      issued    <= '0;
      captured  <= '0;
      rd_pend   <= 1'b0;
      sum_out   <= '0;
      sum_valid <= 1'b0;
    end else begin
      // Sample requested on this edge appears on fifo_dout next cycle.
      rd_pend <= fifo_read;
      unique case (state)
        IDLE: begin
          acc      <= '0;
          issued   <= '0;
          captured <= '0;
          if (!fifo_empty) state <= ACCUM;
        end
        ACCUM: begin
          if (fifo_read) issued <= issued + CNT_W'(1);
          if (rd_pend) begin
            acc      <= add_res;
            captured <= captured + CNT_W'(1);
            if (captured == CNT_W'(BURST_LEN - 1)) begin
              state     <= HOLD;
              sum_out   <= add_res;
              sum_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (sum_ready) begin
            state     <= IDLE;
            sum_valid <= 1'b0;
            acc       <= '0;
            issued    <= '0;
            captured  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_accumulator.sv
// Self-checking bench: behavioural FIFO plus a burst-sum reference model fed from the
// pushed sample stream; directed scenarios followed by randomized traffic.
module tb_fifo_burst_accumulator;

  localparam int DW = 8;
  localparam int BL = 4;
  localparam int AW = 10;
  localparam int AL = 2;

`ifdef APPROX_ADD_EN
  localparam int EXP_1234 = 11;
  localparam int EXP_3333 = 15;
  localparam int EXP_5678 = 27;
  localparam int EXP_FF   = 1023;
`else
  localparam int EXP_1234 = 10;
  localparam int EXP_3333 = 12;
  localparam int EXP_5678 = 26;
  localparam int EXP_FF   = 1020;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_read;
  logic [AW-1:0] sum_out;
  logic          sum_valid;
  logic          sum_ready = 1'b0;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_sums   = 0;

  logic [DW-1:0] q[$];
  int            exp_samples[$];

  fifo_burst_accumulator #(
    .DATA_WIDTH (DW),
    .BURST_LEN  (BL),
    .ACC_WIDTH  (AW),
    .APPROX_LSB (AL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_read  (fifo_read),
    .sum_out    (sum_out),
    .sum_valid  (sum_valid),
    .sum_ready  (sum_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_add(input int a, input int b);
    int mask;
    mask = (1 << AW) - 1;
`ifdef APPROX_ADD_EN
    begin
      int lo, c, hi;
      lo = (a | b) & ((1 << AL) - 1);
      c  = ((a >> (AL - 1)) & (b >> (AL - 1))) & 1;
      hi = ((a >> AL) + (b >> AL) + c) << AL;
      return (hi | lo) & mask;
    end
`else
    return (a + b) & mask;
`endif
  endfunction

  // Registered-output FIFO: dout and empty update on the same edge as a pop.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      fifo_empty <= 1'b1;
      fifo_dout  <= '0;
    end else begin
      if (fifo_read && !fifo_empty) fifo_dout <= q.pop_front();
      fifo_empty <= (q.size() == 0);
    end
  end

  // Scoreboard: each handshake consumes the next BL pushed samples.
  always @(negedge clk) begin
    if (rst) begin
      if (fifo_empty) check_eq("rd_when_empty", int'(fifo_read), 0);
      if (sum_valid && sum_ready) begin
        if (exp_samples.size() < BL) begin
          check_eq("sb_underflow", exp_samples.size(), BL);
        end else begin
          int acc;
          acc = 0;
          for (int i = 0; i < BL; i++) acc = ref_add(acc, exp_samples.pop_front());
          check_eq("burst_sum", int'(sum_out), acc);
        end
        n_sums++;
      end
    end
  end

  task automatic push(input int v);
    logic [DW-1:0] b;
    b = v[DW-1:0];
    q.push_back(b);
    exp_samples.push_back(int'(b));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string tag);
    int c;
    c = 0;
    while (!sum_valid && c < 64) begin
      @(negedge clk);
      c++;
    end
    if (!sum_valid) check_eq({tag, "_timeout"}, 0, 1);
  endtask

  task automatic accept();
    cyc();
    sum_ready = 1'b1;
    cyc();
    sum_ready = 1'b0;
  endtask

  initial begin
    int t_idle, lat, reads, run, max_run, base;
    bit got;
    logic [AW-1:0] held;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_sum_out", int'(sum_out), 0);
    check_eq("rst_sum_valid", int'(sum_valid), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_fifo_read", int'(fifo_read), 0);
    cyc();
    rst = 1'b1;
    repeat (2) cyc();

    // Burst 1,2,3,4: latency and back-to-back reads
    push(1); push(2); push(3); push(4);
    t_idle = -1; lat = -1; reads = 0; run = 0; max_run = 0; got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (sum_valid) begin
        got = 1;
        lat = c - t_idle;
      end else begin
        if (!busy && !fifo_empty) t_idle = c;
        if (fifo_read) begin
          reads++;
          run++;
          if (run > max_run) max_run = run;
        end else begin
          run = 0;
        end
      end
    end
    check_eq("t1_valid_seen", int'(got), 1);
    check_eq("t1_latency", lat, BL + 2);
    check_eq("t1_reads", reads, BL);
    check_eq("t1_consecutive", max_run, BL);
    check_eq("t1_sum", int'(sum_out), EXP_1234);

    // Hold with sum_ready low while the FIFO refills
    held = sum_out;
    cyc();
    push(3); push(3); push(3); push(3);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("hold_valid", int'(sum_valid), 1);
      check_eq("hold_sum", int'(sum_out), int'(held));
      check_eq("hold_no_read", int'(fifo_read), 0);
    end
    accept();
    @(negedge clk);
    check_eq("hs_valid_drop", int'(sum_valid), 0);
    check_eq("hs_idle", int'(busy), 0);
    @(negedge clk);
    check_eq("hs_restart", int'(busy), 1);
    wait_valid("t3");
    check_eq("t3_sum", int'(sum_out), EXP_3333);
    accept();

    // FIFO empties mid-burst
    repeat (2) cyc();
    push(5); push(6);
    repeat (8) @(negedge clk);
    check_eq("stall_busy", int'(busy), 1);
    check_eq("stall_no_valid", int'(sum_valid), 0);
    cyc();
    push(7); push(8);
    wait_valid("t4");
    check_eq("t4_sum", int'(sum_out), EXP_5678);
    accept();

    // Reset after two captures
    repeat (2) cyc();
    push(100); push(100); push(100); push(100);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_samples.delete();
    #1;
    check_eq("arst_fifo_read", int'(fifo_read), 0);
    check_eq("arst_busy", int'(busy), 0);
    check_eq("arst_valid", int'(sum_valid), 0);
    check_eq("arst_sum_out", int'(sum_out), 0);
    repeat (2) cyc();
    rst = 1'b1;
    repeat (2) cyc();
    push(255); push(255); push(255); push(255);
    wait_valid("t5");
    check_eq("t5_sum", int'(sum_out), EXP_FF);
    accept();

    // Back-to-back bursts with sum_ready tied high
    repeat (2) cyc();
    sum_ready = 1'b1;
    base = n_sums;
    for (int i = 0; i < 2 * BL; i++) push(255);
    for (int c = 0; c < 60 && n_sums < base + 2; c++) cyc();
    repeat (4) cyc();
    check_eq("b2b_count", n_sums - base, 2);
    check_eq("b2b_leftover", exp_samples.size(), 0);
    sum_ready = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cyc();
      sum_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) push(int'($urandom_range(0, 255)));
    end
    sum_ready = 1'b1;
    for (int c = 0; c < 400 && (exp_samples.size() >= BL || sum_valid); c++) cyc();
    check_eq("rand_drained", int'(exp_samples.size() < BL), 1);
    check_eq("rand_no_valid", int'(sum_valid), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
